lane_sat_accum: RTL and testbench
=================================

// Module: lane_sat_accum
// PURPOSE
//   Multi-lane signed frame accumulator, generalised from fixed 8-bit signed/unsigned port groups.
//   - Each beat carries NUM_CH signed W-bit samples and one unsigned W-bit bias.
//   - Every lane accumulates sample+bias, saturating, over a frame of up to MAX_BEATS beats.
//   - Per-lane sums, beat count and per-lane saturation flags are returned over a valid/ready output.
//   - Sits between sample front-ends and downstream reduction logic.
// PARAMETERS
//   W         8                       sample/bias width
//   NUM_CH    3                       number of signed lanes
//   ACC_W     12                      signed accumulator width; must be >= W+2
//   MAX_BEATS 16                      frame auto-closes after this many beats; >= 1
//   CNT_W     $clog2(MAX_BEATS+1)     beat counter width (derived)
// PORTS
//   clk        in   1             clock; all state updates on posedge
//   rst_n      in   1             synchronous, active-low reset
//   in_valid   in   1             input beat valid
//   in_ready   out  1             block can accept a beat
//   in_bias    in   W             unsigned bias, added to every lane
//   in_data    in   NUM_CH*W      packed signed samples, lane i at [i*W +: W]
//   in_last    in   1             closes the frame with this beat
//   out_valid  out  1             frame result valid
//   out_ready  in   1             consumer accepts result
//   out_sum    out  NUM_CH*ACC_W  packed signed saturated sums, lane i at [i*ACC_W +: ACC_W]
//   out_beats  out  CNT_W         unsigned beats in the frame (1..MAX_BEATS)
//   out_sat    out  NUM_CH        sticky per-lane saturation flag for the frame
// BEHAVIOUR
//   - Reset (rst_n low at posedge):
//     - state=IDLE, accumulators and beat count = 0.
//     - out_valid=0, out_sum=0, out_beats=0, out_sat=0.
//     - in_ready=1 from the first cycle after rst_n returns high.
//   - Reset has priority over every other event; a partial frame is discarded.
//   - States: IDLE (no beat yet), ACCUM (>=1 beat taken), HOLD (result presented).
//   - in_ready = (state != HOLD). A beat is accepted when in_valid && in_ready.
//   - Per accepted beat, per lane: acc' = sat(acc + sext(data_i) + zext(bias)).
//     - The sum is computed at ACC_W+2 bits, then clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
//     - sat_i |= clamp occurred.
//   - Frame close: an accepted beat with in_last=1, or the beat that makes count==MAX_BEATS.
//     - Both conditions together = one close.
//   - On close (including that beat's contribution):
//     - Final sums, count and flags are loaded into the output registers.
//     - State goes to HOLD; out_valid=1 on the next cycle (latency 1).
//   - IDLE->ACCUM on a non-closing accepted beat.
//   - IDLE->HOLD directly on a closing first beat (MAX_BEATS=1 or in_last).
//   - HOLD: outputs stable, in_ready=0, in_valid is ignored.
//     - On out_valid && out_ready: accumulators, count and flags are cleared; state goes to IDLE.
//     - in_ready rises the following cycle; there is no same-cycle input bypass.
//   - Outputs are registered; they change only at load, handshake-clear or reset.
// STRUCTURE
//   - Package lane_sat_accum_pkg:
//     - state_e enum {IDLE, ACCUM, HOLD}.
//     - function sat_clamp(value, width).
//   - Sub-module sat_add_lane: one lane's adder, clamp and sticky flag; NUM_CH instances via generate.
//   - Top level holds the FSM, beat counter and output registers.
// TESTING (defaults: W=8, NUM_CH=3, ACC_W=12, MAX_BEATS=16)
//   1. rst_n low 2 cycles, then high -> out_valid=0, out_sum=0, out_sat=0; in_ready=1 next cycle.
//   2. 4 beats, bias=0, lanes (10,-3,-128), in_last on beat 4
//      -> out_valid 1 cycle later, sums (40,-12,-512), out_beats=4, out_sat=000.
//   3. 16 beats, bias=255, lanes (127,-128,0), no in_last
//      -> auto-close, sums (2047,2032,4080->2047), out_sat=101, out_beats=16.
//   4. 16 beats, bias=0, lane2=-128 -> lane2 sum=-2048 exactly, out_sat[2]=0 (boundary, no clamp).
//   5. Hold out_ready=0 for 5 cycles with in_valid=1 -> out_valid and out_sum stable, in_ready=0, no beat taken;
//      pulse out_ready -> out_valid=0, in_ready=1 next cycle.
//   6. rst_n low for 1 cycle after 3 beats; then 1 beat (5,5,5) with in_last -> sums (5,5,5), out_beats=1.

Source files
------------

// File: rtl/lane_sat_accum_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lane_sat_accum_pkg
// Description : Shared types and helpers for the multi-lane saturating
//               frame accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package lane_sat_accum_pkg;

    // Frame FSM: no beat yet, beats being gathered, result presented.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_e;

    // Clamp a sign-extended value to the signed range of 'width' bits.
    // The result is returned sign-extended to 64 bits so the caller can
    // detect a clamp by comparing against the unclamped value.
    function automatic logic signed [63:0] sat_clamp(
        input logic signed [63:0] value,
        input int                 width
    );
        logic signed [63:0] v_max;
        logic signed [63:0] v_min;
        v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
        v_min = -v_max - 64'sd1;
        if (value > v_max) begin
            return v_max;
        end else if (value < v_min) begin
            return v_min;
        end
        return value;
    endfunction

endpackage : lane_sat_accum_pkg
`default_nettype wire

// File: rtl/lane_sat_accum_lane.sv
`default_nettype none
// ============================================================================
// Module      : sat_add_lane
// Description : One accumulator lane: acc + sext(sample) + zext(bias),
//               clamped to ACC_W signed bits, with a sticky clamp flag.
//               Exposes the post-beat value so the top level can capture
//               the closing beat's contribution in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_add_lane
    import lane_sat_accum_pkg::*;
#(
    parameter int W     = 8,
    parameter int ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic [W-1:0]     i_data,
    input  logic [W-1:0]     i_bias,
    output logic [ACC_W-1:0] o_acc_next,
    output logic             o_sat_next
);

    localparam int c_SUM_W = ACC_W + 2;

    logic [ACC_W-1:0]          r_acc;
    logic                      r_sat;
    logic signed [c_SUM_W-1:0] w_sum;
    logic signed [63:0]        w_wide;
    logic signed [63:0]        w_clamped;
    logic                      w_clip;

    // Two guard bits hold the worst case acc + max sample + max bias.
    assign w_sum = $signed({{2{r_acc[ACC_W-1]}}, r_acc})
                 + $signed({{(c_SUM_W-W){i_data[W-1]}}, i_data})
                 + $signed({{(c_SUM_W-W){1'b0}}, i_bias});

    assign w_wide     = {{(64-c_SUM_W){w_sum[c_SUM_W-1]}}, w_sum};
    assign w_clamped  = sat_clamp(w_wide, ACC_W);
    assign w_clip     = (w_clamped != w_wide);
    assign o_acc_next = w_clamped[ACC_W-1:0];
    assign o_sat_next = r_sat | w_clip;

    // Accumulate on accepted beats; frame handshake or reset clears the lane.
    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= o_acc_next;
            r_sat <= o_sat_next;
        end
    end

endmodule : sat_add_lane
`default_nettype wire

// File: rtl/lane_sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : lane_sat_accum
// Description : Multi-lane signed saturating frame accumulator with
//               valid/ready input and output. Frames close on in_last or
//               after MAX_BEATS beats; results are held until accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module lane_sat_accum
    import lane_sat_accum_pkg::*;
#(
    parameter int W         = 8,
    parameter int NUM_CH    = 3,
    parameter int ACC_W     = 12,
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_bias,
    input  logic [NUM_CH*W-1:0]     in_data,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_CH*ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0]        out_beats,
    output logic [NUM_CH-1:0]       out_sat
);

    localparam logic [CNT_W-1:0] c_MAX_CNT = CNT_W'(MAX_BEATS);

    state_e                    r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic                      r_out_valid;
    logic [NUM_CH*ACC_W-1:0]   r_out_sum;
    logic [CNT_W-1:0]          r_out_beats;
    logic [NUM_CH-1:0]         r_out_sat;

    logic                      w_accept;
    logic                      w_close;
    logic                      w_clr;
    logic [CNT_W-1:0]          w_cnt_next;
    logic [NUM_CH*ACC_W-1:0]   w_sum_next;
    logic [NUM_CH-1:0]         w_sat_next;

    assign in_ready   = (r_state != HOLD);
    assign w_accept   = in_valid && in_ready;
    assign w_cnt_next = r_cnt + 1'b1;
    assign w_close    = w_accept && (in_last || (w_cnt_next == c_MAX_CNT));
    assign w_clr      = r_out_valid && out_ready;

    assign out_valid  = r_out_valid;
    assign out_sum    = r_out_sum;
    assign out_beats  = r_out_beats;
    assign out_sat    = r_out_sat;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            sat_add_lane #(
                .W     (W),
                .ACC_W (ACC_W)
            ) u_lane (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_en       (w_accept),
                .i_clr      (w_clr),
                .i_data     (in_data[gi*W +: W]),
                .i_bias     (in_bias),
                .o_acc_next (w_sum_next[gi*ACC_W +: ACC_W]),
                .o_sat_next (w_sat_next[gi])
            );
        end
    endgenerate

    // Frame FSM: count beats, capture the result on close, release on handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_beats <= '0;
            r_out_sat   <= '0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        r_cnt <= w_cnt_next;
                        if (w_close) begin
                            r_state     <= HOLD;
                            r_out_valid <= 1'b1;
                            r_out_sum   <= w_sum_next;
                            r_out_beats <= w_cnt_next;
                            r_out_sat   <= w_sat_next;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (w_clr) begin
                        r_state     <= IDLE;
                        r_cnt       <= '0;
                        r_out_valid <= 1'b0;
                        r_out_sum   <= '0;
                        r_out_beats <= '0;
                        r_out_sat   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule : lane_sat_accum
`default_nettype wire

// File: tb/tb_lane_sat_accum.sv
`default_nettype none
// ============================================================================
// Module      : tb_lane_sat_accum
// Description : Self-checking bench for lane_sat_accum with a behavioural
//               frame model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lane_sat_accum;

    localparam int c_W      = 8;
    localparam int c_NCH    = 3;
    localparam int c_ACC_W  = 12;
    localparam int c_MAXB   = 16;
    localparam int c_CNT_W  = $clog2(c_MAXB + 1);
    localparam int c_HI     = (1 << (c_ACC_W - 1)) - 1;
    localparam int c_LO     = -(1 << (c_ACC_W - 1));

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic                     in_ready;
    logic [c_W-1:0]           in_bias;
    logic [c_NCH*c_W-1:0]     in_data;
    logic                     in_last;
    logic                     out_valid;
    logic                     out_ready;
    logic [c_NCH*c_ACC_W-1:0] out_sum;
    logic [c_CNT_W-1:0]       out_beats;
    logic [c_NCH-1:0]         out_sat;

    int checks = 0;
    int errors = 0;

    // Frame model: running sums and the captured result of a closed frame.
    int m_acc [c_NCH];
    int m_sat [c_NCH];
    int m_cnt;
    bit m_hold;
    int e_sum [c_NCH];
    int e_sat [c_NCH];
    int e_beats;

    lane_sat_accum #(
        .W         (c_W),
        .NUM_CH    (c_NCH),
        .ACC_W     (c_ACC_W),
        .MAX_BEATS (c_MAXB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bias   (in_bias),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_beats (out_beats),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < c_NCH; i++) begin
            m_acc[i] = 0;
            m_sat[i] = 0;
        end
        m_cnt = 0;
    endfunction

    function automatic void model_beat(input int d0, input int d1, input int d2,
                                       input int bias, input bit last);
        int d [c_NCH];
        d[0] = d0; d[1] = d1; d[2] = d2;
        for (int i = 0; i < c_NCH; i++) begin
            int v;
            v = m_acc[i] + d[i] + bias;
            if (v > c_HI) begin v = c_HI; m_sat[i] = 1; end
            if (v < c_LO) begin v = c_LO; m_sat[i] = 1; end
            m_acc[i] = v;
        end
        m_cnt++;
        if (last || m_cnt == c_MAXB) begin
            for (int i = 0; i < c_NCH; i++) begin
                e_sum[i] = m_acc[i];
                e_sat[i] = m_sat[i];
            end
            e_beats = m_cnt;
            m_hold  = 1'b1;
            model_clear();
        end
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".out_valid"}, int'(out_valid), int'(m_hold));
        check_val({tag, ".in_ready"}, int'(in_ready), int'(!m_hold));
        if (m_hold) begin
            for (int i = 0; i < c_NCH; i++) begin
                logic signed [c_ACC_W-1:0] s;
                s = out_sum[i*c_ACC_W +: c_ACC_W];
                check_val($sformatf("%s.sum%0d", tag, i), int'(s), e_sum[i]);
                check_val($sformatf("%s.sat%0d", tag, i), int'(out_sat[i]), e_sat[i]);
            end
            check_val({tag, ".beats"}, int'(out_beats), e_beats);
        end
    endtask

    // One cycle with in_valid high; the model only takes the beat if not holding.
    task automatic drive_beat(input string tag, input int d0, input int d1, input int d2,
                              input int bias, input bit last);
        bit taken;
        in_valid = 1'b1;
        in_data  = {8'(d2), 8'(d1), 8'(d0)};
        in_bias  = 8'(bias);
        in_last  = last;
        taken    = !m_hold;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (taken) model_beat(d0, d1, d2, bias, last);
        check_outputs(tag);
    endtask

    // Stall the consumer for 'stall' cycles with input pressure, then accept.
    task automatic drain(input string tag, input int stall);
        out_ready = 1'b0;
        for (int k = 0; k < stall; k++) begin
            drive_beat({tag, ".stall"}, int'($urandom_range(255)) - 128, 7, -7, 3, 1'b1);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        m_hold = 1'b0;
        check_val({tag, ".clr_valid"}, int'(out_valid), 0);
        check_val({tag, ".clr_ready"}, int'(in_ready), 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bias   = '0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        m_hold    = 1'b0;
        e_beats   = 0;
        model_clear();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_val("rst.out_valid", int'(out_valid), 0);
        check_val("rst.out_sum_zero", int'(out_sum == '0), 1);
        check_val("rst.out_sat", int'(out_sat), 0);
        check_val("rst.out_beats", int'(out_beats), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("rst.in_ready", int'(in_ready), 1);

        // Four beats closed by in_last
        for (int b = 0; b < 4; b++) drive_beat("t2", 10, -3, -128, 0, b == 3);
        check_val("t2.sum2_direct", int'($signed(out_sum[2*c_ACC_W +: c_ACC_W])), -512);
        drain("t2", 0);

        // Sixteen beats, auto-close, clamping in lanes 0 and 2
        for (int b = 0; b < 16; b++) drive_beat("t3", 127, -128, 0, 255, 1'b0);
        check_val("t3.sat_vec", int'(out_sat), 5);
        check_val("t3.beats_direct", int'(out_beats), 16);
        drain("t3", 0);

        // Lane 2 lands exactly on the negative limit without clamping
        for (int b = 0; b < 16; b++) drive_beat("t4", 1, 2, -128, 0, 1'b0);
        check_val("t4.sum2_direct", int'($signed(out_sum[2*c_ACC_W +: c_ACC_W])), -2048);
        // Result held under back-pressure with in_valid high
        drain("t5", 5);

        // Mid-frame reset discards the partial frame
        for (int b = 0; b < 3; b++) drive_beat("t6a", 100, 100, 100, 200, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_clear();
        m_hold = 1'b0;
        check_val("t6.rst_valid", int'(out_valid), 0);
        drive_beat("t6", 5, 5, 5, 0, 1'b1);
        check_val("t6.beats_direct", int'(out_beats), 1);
        drain("t6", 1);

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            int bias;
            bias = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(8));
            drive_beat("rnd",
                       int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128,
                       int'($urandom_range(255)) - 128,
                       bias, $urandom_range(7) == 0);
            if (m_hold) drain("rnd", int'($urandom_range(3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_lane_sat_accum
`default_nettype wire
